serial_fifo_param: RTL
======================

Name: serial_fifo_param

Overview:
- Parametrised successor to the serial GPIO peripheral's fixed 9-bit x 16 FIFO.
- Sits between the AXI register interface and the UART TX/RX datapath; one instance per direction.
- Adds the following over the fixed FIFO:
  - configurable data width and depth
  - selectable edge- or level-qualified requests
  - synchronous flush
  - sticky underflow as well as overflow
  - a programmable threshold interrupt flag

Parameters:
- DATA_W, 9, data word width in bits (>=1).
- ADDR_W, 4, log2 of depth; depth = 2**ADDR_W (1..8).
- EDGE_REQ, 1, 1 = wr_request/rd_request are rising-edge detected (bus strobes held several cycles); 0 = level, one operation per cycle while high.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_request  in  1  write strobe (qualified per EDGE_REQ).
- rd_request  in  1  read/pop strobe (qualified per EDGE_REQ).
- wr_data  in  DATA_W  data written on accepted write.
- rd_data  out  DATA_W  registered head-of-FIFO word.
- flush  in  1  synchronous flush; empties the FIFO.
- clear_status  in  1  clears overflow and underflow.
- threshold  in  ADDR_W+1  level threshold for thresh_hit.
- empty  out  1  level == 0.
- full  out  1  level == 2**ADDR_W.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.
- thresh_hit  out  1  level >= threshold.
- level  out  ADDR_W+1  current occupancy (watermark).
- wr_index  out  ADDR_W+1  write pointer with wrap bit.
- rd_index  out  ADDR_W+1  read pointer with wrap bit.

Behaviour:
- Reset (reset==0, async):
  - pointers = 0, overflow = underflow = 0
  - rd_data = 0, empty = 1, full = 0, level = 0, thresh_hit = (threshold==0) after the first clock
  - memory contents are not reset.
- Request qualification:
  - EDGE_REQ=1: the internal request is in & ~in_q. in_q resets to 0 asynchronously, so a request held high through reset release fires once on the first clock.
  - EDGE_REQ=0: the internal request equals the input.
- Pointers: ADDR_W+1 bits, increment modulo 2**(ADDR_W+1). Memory is addressed by [ADDR_W-1:0].
- full / empty are decoded combinationally from the registered pointers:
  - full: MSBs differ and the low bits are equal.
  - empty: pointers equal.
- Accepted write (wreq & ~full): mem[wr_index] <= wr_data; wr_index++.
- Rejected write (wreq & full): overflow <= 1; data is dropped; pointers are unchanged.
- Accepted read (rreq & ~empty): rd_index++.
- Rejected read (rreq & empty): underflow <= 1; no pointer change.
- Simultaneous read and write:
  - full/empty are evaluated on pre-update pointers.
  - When full, the write is rejected (overflow set) and the read proceeds.
  - When empty, the read is rejected (underflow set) and the write proceeds.
  - Otherwise both proceed and level is unchanged.
- rd_data: registered each cycle from mem[rd_index] (show-ahead).
  - Valid one clock after any pointer change.
  - A word written into an empty FIFO appears on rd_data 2 clocks after the write is accepted.
- level = wr_index - rd_index (ADDR_W+1 bits, no saturation needed); registered, 1-cycle lag behind the pointers.
- thresh_hit = (level >= threshold), registered. A threshold greater than the depth means thresh_hit is never set.
- flush:
  - Sets both pointers to 0 next cycle.
  - Takes priority over read and write in the same cycle; neither request is counted.
  - Sticky flags are unaffected.
- clear_status:
  - Clears overflow and underflow.
  - A new set event in the same cycle wins (the flag stays 1).

Optional Feature:
- Macro SERIAL_FIFO_PEAK_EN.
- When defined:
  - Adds output peak_level [ADDR_W:0], the maximum level since reset or the last clear_status.
  - Updated one cycle after level.
  - clear_status loads the current level.
- When undefined: no port and no logic; the rest of the behaviour is identical.

Decomposition:
- Package serial_fifo_pkg:
  - default DATA_W/ADDR_W localparams
  - function depth(addr_w)
  - typedef of the pointer struct {wrap, addr}.
- Sub-module req_qualify: edge/level request qualifier, instanced twice, parameter EDGE.

Test Plan:
- Reset then write 0x1A5 once (EDGE_REQ=1, strobe held 3 cycles) -> exactly one entry; level=1; rd_data=0x1A5 two clocks after the write is accepted; empty=0.
- Write 16 words 0..15 with ADDR_W=4, then a 17th (0x0FF) -> full=1, overflow=1, level=16; 16 reads return 0..15 in order, then empty=1.
- Fill to 8, threshold=8 -> thresh_hit=1; one read -> thresh_hit=0 within 2 clocks.
- Read when empty -> underflow=1, rd_index unchanged; clear_status coinciding with a second empty read -> underflow stays 1.
- Wrap-around: 40 alternating write/read pairs (EDGE_REQ=0, simultaneous) -> data integrity, level constant; wr_index passes 31 -> 0.
- Level at 5, assert flush together with wr_request -> level=0, empty=1, overflow unchanged; async reset mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/serial_fifo_pkg.sv
// -----------------------------------------------------------------------------
// serial_fifo_pkg
// Shared definitions for the parametrised serial FIFO:
//   - default word width / address width
//   - depth() helper (entries for a given address width)
//   - fifo_ptr_t: pointer layout {wrap, addr} at the default address width
// -----------------------------------------------------------------------------
package serial_fifo_pkg;

  localparam int DEFAULT_DATA_W = 9;
  localparam int DEFAULT_ADDR_W = 4;

  // A pointer carries one extra wrap bit above the memory address so that
  // full (same address, different lap) and empty (identical) can be told apart.
  typedef struct packed {
    logic                      wrap;
    logic [DEFAULT_ADDR_W-1:0] addr;
  } fifo_ptr_t;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/req_qualify.sv
// -----------------------------------------------------------------------------
// req_qualify
// Turns a raw request strobe into a one-operation request.
//   EDGE = 1 : req_o pulses for one cycle on each rising edge of req_i
//              (bus strobes that are held high for several cycles).
//   EDGE = 0 : req_o follows req_i, one operation per cycle while high.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-low reset
//   req_i  in  raw request
//   req_o  out qualified request
// -----------------------------------------------------------------------------
module req_qualify #(
  parameter bit EDGE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  output logic req_o
);

  logic req_q;

  // Cleared by reset so that a request already high when reset releases
  // is seen as a rising edge on the first clock.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) req_q <= 1'b0;
    else        req_q <= req_i;
  end

  // With EDGE = 0 the history term folds to zero and req_o == req_i.
  assign req_o = req_i & ~(req_q & EDGE);

endmodule

// File: rtl/serial_fifo_param.sv
// -----------------------------------------------------------------------------
// serial_fifo_param
// Parametrised synchronous FIFO between the register interface and the UART
// datapath. Show-ahead registered read data, sticky overflow/underflow,
// synchronous flush, registered level and threshold flag.
//
// Optional build macro: SERIAL_FIFO_PEAK_EN adds peak_level (maximum level
// since reset or the last clear_status).
//
// Ports:
//   clock, reset            clock / asynchronous active-low reset
//   wr_request, rd_request  write / pop strobes (qualified per EDGE_REQ)
//   wr_data / rd_data       write word / registered head-of-FIFO word
//   flush                   synchronous empty, wins over read and write
//   clear_status            clears overflow / underflow
//   threshold               level threshold for thresh_hit
//   empty, full             decoded from the registered pointers
//   overflow, underflow     sticky error flags
//   thresh_hit              level >= threshold (registered)
//   level                   occupancy, one cycle behind the pointers
//   wr_index, rd_index      pointers including wrap bit
//   peak_level              (SERIAL_FIFO_PEAK_EN only) high-water mark
// -----------------------------------------------------------------------------
module serial_fifo_param
  import serial_fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit EDGE_REQ = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_request,
  input  logic              rd_request,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic              clear_status,
  input  logic [ADDR_W:0]   threshold,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              thresh_hit,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   wr_index,
  output logic [ADDR_W:0]   rd_index
`ifdef SERIAL_FIFO_PEAK_EN
  ,output logic [ADDR_W:0]  peak_level
`endif
);

  localparam int DEPTH = depth(ADDR_W);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Same layout as fifo_ptr_t, sized by this instance's ADDR_W.
  typedef struct packed {
    logic              wrap;
    logic [ADDR_W-1:0] addr;
  } ptr_t;

  logic              wreq, rreq;
  logic              wr_ok, rd_ok, wr_rej, rd_rej;
  ptr_t              wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [ADDR_W:0]   level_q;
  logic              thresh_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  req_qualify #(.EDGE(EDGE_REQ)) u_wr_qual (
    .clock (clock), .reset (reset), .req_i (wr_request), .req_o (wreq)
  );
  req_qualify #(.EDGE(EDGE_REQ)) u_rd_qual (
    .clock (clock), .reset (reset), .req_i (rd_request), .req_o (rreq)
  );

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q.wrap != rd_q.wrap) && (wr_q.addr == rd_q.addr);

  // Accept/reject uses pre-update full/empty; flush swallows both requests
  // entirely, so it neither moves pointers nor sets a sticky flag.
  assign wr_ok  = wreq & ~full  & ~flush;
  assign wr_rej = wreq &  full  & ~flush;
  assign rd_ok  = rreq & ~empty & ~flush;
  assign rd_rej = rreq &  empty & ~flush;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_ok) wr_d = ptr_t'(wr_q + PTR_ONE);
      if (rd_ok) rd_d = ptr_t'(rd_q + PTR_ONE);
    end
    // A set event in the same cycle as clear_status leaves the flag set.
    if (clear_status) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_rej) ovf_d = 1'b1;
    if (rd_rej) udf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      level_q   <= '0;
      thresh_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      level_q   <= wr_q - rd_q;
      thresh_q  <= (level_q >= threshold);
      rd_data_q <= mem[rd_q.addr];
    end
  end

  // NOTE: the storage array has no reset; only pointers and flags define
  // validity, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_q.addr] <= wr_data;
  end

`ifdef SERIAL_FIFO_PEAK_EN
  logic [ADDR_W:0] peak_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 peak_q <= '0;
    else if (clear_status)      peak_q <= level_q;
    else if (level_q > peak_q)  peak_q <= level_q;
  end

  assign peak_level = peak_q;
`endif

  assign rd_data    = rd_data_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign thresh_hit = thresh_q;
  assign level      = level_q;
  assign wr_index   = wr_q;
  assign rd_index   = rd_q;

endmodule
